// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write, one read port) with a clear sequencer that
// sweeps CLR_VAL through every word, either on request or automatically after reset.
module ram_dp_clr #(
  parameter int              DW         = 8,
  parameter int              AW         = 18,
  parameter int              OUT_REG    = 0,
  parameter logic [DW-1:0]   CLR_VAL    = '0,
  parameter int              CLR_ON_RST = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  output logic          BUSY,
  input  logic          WEN,
  input  logic [AW-1:0] WA,
  input  logic [DW-1:0] WD,
  input  logic          REN,
  input  logic [AW-1:0] RA,
  output logic [DW-1:0] RQ,
  output logic          RVALID
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_r, state_nx;
  logic [AW-1:0] cnt_r, cnt_nx;

  logic [DW-1:0] mem [DEPTH];

  logic          rd_acc;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] q1_r;
  logic          v1_r;

  // Clear sequencer: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Clear sequencer: next state; CLR is ignored while a sweep runs
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      IDLE: begin
        if (CLR) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt_r + AW'(1);
        if (&cnt_r) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign BUSY = (state_r == CLEAR);

  // Array write port: the sweep owns the port while clearing
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_r == CLEAR) begin
        mem[cnt_r] <= CLR_VAL;
      end else if (WEN) begin
        mem[WA] <= WD;
      end
    end
  end

  // Write-first forwarding when reading the word being written this cycle
  assign rd_acc  = REN && (state_r == IDLE);
  assign rd_data = (WEN && (WA == RA)) ? WD : mem[RA];

  always_ff @(posedge CLK) begin
    if (RST) begin
      q1_r <= '0;
      v1_r <= 1'b0;
    end else begin
      q1_r <= rd_acc ? rd_data : '0;
      v1_r <= rd_acc;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] q2_r;
      logic          v2_r;

      always_ff @(posedge CLK) begin
        if (RST) begin
          q2_r <= '0;
          v2_r <= 1'b0;
        end else begin
          q2_r <= q1_r;
          v2_r <= v1_r;
        end
      end

      assign RQ     = q2_r;
      assign RVALID = v2_r;
    end else begin : g_noreg
      assign RQ     = q1_r;
      assign RVALID = v1_r;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: three instances (no output reg, output reg, no clear on reset)
// share one stimulus stream; a reference model feeds per-instance expected queues.
module tb_ram_dp_clr;

  localparam int          DW   = 8;
  localparam int          AW   = 4;
  localparam int          NW   = 16;
  localparam logic [7:0]  CVAL = 8'hA5;

  logic          clk = 1'b0;
  logic          rst, clr, wen, ren;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;

  logic          busy0, busy1, busy2;
  logic          rv0, rv1, rv2;
  logic [DW-1:0] rq0, rq1, rq2;

  int n_total = 0;
  int n_bad   = 0;

  // Model state per instance; entry = {dont_care_data, valid, data}
  logic [DW-1:0] m_mem   [3][NW];
  bit            m_known [3][NW];
  int            m_busy  [3];
  int            m_cnt   [3];
  logic [DW+1:0] exp_q0[$];
  logic [DW+1:0] exp_q1[$];
  logic [DW+1:0] exp_q2[$];

  always #5 clk = ~clk;

  ram_dp_clr #(.DW(DW), .AW(AW), .OUT_REG(0), .CLR_VAL(CVAL), .CLR_ON_RST(1)) u0 (
    .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busy0), .WEN(wen), .WA(wa), .WD(wd),
    .REN(ren), .RA(ra), .RQ(rq0), .RVALID(rv0));

  ram_dp_clr #(.DW(DW), .AW(AW), .OUT_REG(1), .CLR_VAL(CVAL), .CLR_ON_RST(1)) u1 (
    .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busy1), .WEN(wen), .WA(wa), .WD(wd),
    .REN(ren), .RA(ra), .RQ(rq1), .RVALID(rv1));

  ram_dp_clr #(.DW(DW), .AW(AW), .OUT_REG(0), .CLR_VAL(CVAL), .CLR_ON_RST(0)) u2 (
    .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busy2), .WEN(wen), .WA(wa), .WD(wd),
    .REN(ren), .RA(ra), .RQ(rq2), .RVALID(rv2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit clr_on_rst(input int i);
    return (i != 2);
  endfunction

  // Advance the reference model by one edge and return the read result it implies
  task automatic model_step(input int i, output logic [DW+1:0] e);
    e = '0;
    if (rst) begin
      m_busy[i] = clr_on_rst(i) ? NW : 0;
      m_cnt[i]  = 0;
    end else if (m_busy[i] > 0) begin
      m_mem[i][m_cnt[i]]   = CVAL;
      m_known[i][m_cnt[i]] = 1'b1;
      m_cnt[i]             = (m_cnt[i] + 1) % NW;
      m_busy[i]--;
    end else begin
      if (ren) begin
        if (wen && (wa == ra)) e = {1'b0, 1'b1, wd};
        else                   e = {~m_known[i][ra], 1'b1, m_mem[i][ra]};
      end
      if (wen) begin
        m_mem[i][wa]   = wd;
        m_known[i][wa] = 1'b1;
      end
      if (clr) begin
        m_busy[i] = NW;
        m_cnt[i]  = 0;
      end
    end
  endtask

  task automatic check_out(input int i, input logic [DW+1:0] x, input logic v,
                           input logic [DW-1:0] q, input logic b);
    chk($sformatf("u%0d_rvalid", i), {31'd0, v}, {31'd0, x[DW]});
    if (!x[DW+1]) chk($sformatf("u%0d_rq", i), {24'd0, q}, {24'd0, x[DW-1:0]});
    chk($sformatf("u%0d_busy", i), {31'd0, b}, {31'd0, (m_busy[i] > 0)});
  endtask

  // One clock: push expectations, take the edge, pop and compare
  task automatic cycle();
    logic [DW+1:0] e0, e1, e2, x0, x1, x2;
    model_step(0, e0);
    model_step(1, e1);
    model_step(2, e2);
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      exp_q1.push_back('0);
    end
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    exp_q2.push_back(e2);
    @(posedge clk);
    #1;
    x0 = exp_q0.pop_front();
    x1 = exp_q1.pop_front();
    x2 = exp_q2.pop_front();
    check_out(0, x0, rv0, rq0, busy0);
    check_out(1, x1, rv1, rq1, busy1);
    check_out(2, x2, rv2, rq2, busy2);
  endtask

  task automatic drive(input logic r, input logic c, input logic we, input logic [AW-1:0] a_w,
                       input logic [DW-1:0] d, input logic re, input logic [AW-1:0] a_r);
    rst = r; clr = c; wen = we; wa = a_w; wd = d; ren = re; ra = a_r;
    cycle();
    rst = 1'b0; clr = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic read_all();
    for (int k = 0; k < NW; k++) rd(AW'(k));
    idle(2);
  endtask

  task automatic fill_addr();
    for (int k = 0; k < NW; k++) wr(AW'(k), DW'(k));
  endtask

  task automatic random_traffic(input int n, input bit allow_clr);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, allow_clr && ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), DW'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0;
      m_cnt[i]  = 0;
      for (int k = 0; k < NW; k++) begin
        m_mem[i][k]   = '0;
        m_known[i][k] = 1'b0;
      end
    end
    rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; wa = '0; ra = '0; wd = '0;

    // Reset held 3 cycles, then the automatic sweep; reads during the sweep are dropped
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, '0);
    idle(NW);
    read_all();

    // Write then read on the next cycle
    wr(4'd7, 8'h3C);
    rd(4'd7);
    idle(3);

    // Independent addresses, then same-address collision with write-first forwarding
    wr(4'd5, 8'h22);
    drive(1'b0, 1'b0, 1'b1, 4'd4, 8'h33, 1'b1, 4'd5);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 8'h11, 1'b1, 4'd5);
    rd(4'd5);
    rd(4'd4);
    idle(3);

    // CLR with traffic in the same cycle and continuously during the sweep
    fill_addr();
    drive(1'b0, 1'b1, 1'b1, 4'd3, 8'h77, 1'b1, 4'd9);
    for (int k = 0; k < NW; k++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, AW'($urandom_range(0, NW - 1)), 8'hEE,
            1'b1, AW'($urandom_range(0, NW - 1)));
    idle(1);
    read_all();

    // Reset at sweep cycle 9: restart on u0/u1, partial clear on u2
    fill_addr();
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(9);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(NW);
    read_all();

    // Streaming reads back-to-back after distinct data
    for (int k = 0; k < NW; k++) wr(AW'(k), DW'($urandom_range(0, 255)));
    read_all();

    random_traffic(200, 1'b1);
    idle(NW + 1);
    read_all();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
# ram_dp_clr

Parametrised simple dual-port RAM (one write port, one read port) with a built-in memory-clear sequencer. Read data can come straight from the array or through an extra output register, and a read from an address being written in the same cycle returns the new data. It is the successor to the fixed 256K×8 single-port frame store in the grayscale/halftone pipeline. The converter can write the halftone output line while reading the next grayscale pixel, and can wipe the frame between images without a software loop.

## Interface
- DW, 8: data width in bits.
- AW, 18: address width; DEPTH = 2^AW words.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- CLR_VAL, 0: DW-bit value written to every word by a clear sweep.
- CLR_ON_RST, 1: 1 runs a clear sweep automatically after reset; 0 does not.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CLR  in  1  single-cycle request to start a clear sweep.
- BUSY  out  1  high while a clear sweep is in progress or pending.
- WEN  in  1  write enable.
- WA  in  AW  write address.
- WD  in  DW  write data.
- REN  in  1  read enable.
- RA  in  AW  read address.
- RQ  out  DW  read data.
- RVALID  out  1  high when RQ holds data for an accepted read.

## Operation
- The FSM has two states, IDLE and CLEAR, plus a clear counter `cnt` of AW bits.
- While RST is high:
  - State = CLEAR if CLR_ON_RST=1, otherwise IDLE.
  - cnt = 0.
  - No array writes occur.
  - RQ = 0, RVALID = 0, and the OUT_REG pipeline stage is zeroed.
- BUSY = (state == CLEAR), and is driven combinationally from the state register.
- IDLE:
  - WEN=1 writes mem[WA] <= WD.
  - REN=1 reads mem[RA].
  - CLR=1 moves the FSM to CLEAR with cnt=0 on the next edge. Any WEN or REN in the same cycle as CLR is still serviced.
- CLEAR:
  - Each edge writes mem[cnt] <= CLR_VAL and increments cnt.
  - The edge that writes DEPTH-1 returns the FSM to IDLE; cnt wraps to 0.
  - WEN, REN and CLR are ignored. A CLR during CLEAR does not restart the sweep.
- Read-during-write to the same address (REN & WEN & RA==WA, in IDLE): the read returns WD, i.e. write-first forwarding. Different addresses are fully independent.
- Read data rules:
  - An accepted read (REN=1 in IDLE) produces RQ = data and RVALID = 1.
  - A cycle without an accepted read produces RQ = 0 and RVALID = 0. This matches the existing "Q=0 when not reading" convention.
- Uninitialised contents are X in simulation until written or cleared.
- Asserting RST mid-sweep aborts the sweep. After RST release the sweep restarts from address 0 if CLR_ON_RST=1; if CLR_ON_RST=0 the contents are partially cleared and the FSM sits in IDLE.

## Timing
- Read latency is counted from the edge that samples REN:
  - OUT_REG=0: RQ and RVALID are valid after 1 edge.
  - OUT_REG=1: RQ and RVALID are valid after 2 edges.
- Back-to-back reads every cycle are supported, giving one result per cycle.
- Write latency: data is stored at the edge that samples WEN. A read of the same address issued on the next cycle returns the new data.
- Clear sweep duration: BUSY is high for exactly DEPTH cycles.
  - For CLR: counted from the edge that samples CLR=1.
  - For the automatic sweep: counted from the first edge with RST low.
- The first accepted access is in the cycle after BUSY falls.
- Reads issued before a sweep still drain through the OUT_REG stage normally. RVALID for them may appear while BUSY=1.

## Test plan
- Reset, DW=8, AW=4, CLR_ON_RST=1, CLR_VAL=8'hA5: hold RST 3 cycles, then release. Required: BUSY=1 for exactly 16 cycles after release, RQ=0 and RVALID=0 throughout, then reads of addresses 0..15 all return 8'hA5.
- Write then read, OUT_REG=0: write 8'h3C to address 7, then REN with RA=7 on the next cycle. Required: RQ=8'h3C and RVALID=1 one cycle later. Repeat with OUT_REG=1: RQ=8'h3C with a 2-cycle latency.
- Collision: in the same cycle WEN with WA=5, WD=8'h11 and REN with RA=5, where the old value is 8'h22. Required: RQ=8'h11. Also a simultaneous write to address 4 and read of address 5 returns 8'h22.
- CLR mid-traffic: fill the array with address values, pulse CLR, and drive WEN/REN continuously during BUSY. Required: BUSY high for 16 cycles, no RVALID generated by the ignored reads, and every word reads CLR_VAL afterwards.
- Reset mid-sweep with CLR_ON_RST=1: assert RST at sweep cycle 9 for 1 cycle. Required: the sweep restarts and BUSY stays high for 16 cycles after release. With CLR_ON_RST=0, BUSY drops immediately and addresses 0..8 read CLR_VAL while 9..15 keep their old data.
- Streaming: 16 consecutive reads of addresses 0..15 with REN held high, OUT_REG=1. Required: RVALID stays high for 16 consecutive cycles starting 2 cycles after the first read, with the data in address order.
